// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive controller:
//               FSM state encoding, default widths and legal prescale values.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

  // Default frame geometry.
  localparam int DATA_BITS_DEF  = 8;
  localparam int PRESCALE_W_DEF = 6;

  // Supported oversampling ratios; anything else falls back to 8.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Receiver FSM states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Map a requested prescale onto a supported ratio.
  function automatic int norm_prescale(input int ps);
    if (ps == PRESCALE_16 || ps == PRESCALE_32) begin
      return ps;
    end
    return PRESCALE_8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_edge_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_edge_bit_counter
// Description : Oversample (edge) counter and bit counter for the UART
//               receiver. Edge counter wraps at last_edge and advances the
//               bit counter; clr has priority over en.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_edge_bit_counter #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] last_edge,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;

  // Next-count logic: clear, wrap-and-advance, or plain increment.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (en) begin
      if (edge_cnt_q == last_edge) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  // Counter registers with asynchronous active-low reset.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt = edge_cnt_q;
  assign bit_cnt  = bit_cnt_q;
  // Final oversample of the current bit while counting.
  assign bit_end  = en && (edge_cnt_q == last_edge);

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fsm
// Description : UART receive controller. Detects the start edge, walks the
//               frame bit by bit using the edge/bit counter, pulses the
//               sampler/deserializer/checker enables mid-bit and raises a
//               one-cycle data_valid when a frame is accepted.
//               Optional parity support is compiled in with the macro
//               UART_RX_PARITY_EN; without it par_en/par_err are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt
);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic                  samp_q, samp_d;
  logic                  deser_q, deser_d;
  logic                  strt_q, strt_d;
  logic                  stp_q, stp_d;
  logic                  par_chk_q, par_chk_d;
  logic                  par_active;

  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  bit_end;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] last_edge;
  logic [PRESCALE_W-1:0] ps_norm;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  assign par_active = par_q;
`else
  logic unused_par_en;
  assign unused_par_en = par_en;
  assign par_active    = 1'b0;
`endif

  assign ps_norm   = PRESCALE_W'(norm_prescale(int'(prescale)));
  assign mid       = ps_q >> 1;
  assign last_edge = ps_q - PRESCALE_W'(1);

  uart_rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_cnt (
    .clk2      (clk2),
    .rst       (rst),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .last_edge (last_edge),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .bit_end   (bit_end)
  );

  // Next-state, counter control, latching and strobe look-ahead.
  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    cnt_en     = (state_q != ST_IDLE);
    cnt_clr    = 1'b0;
    data_valid = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_in) begin
          state_d = ST_START;
          ps_d    = ps_norm;
`ifdef UART_RX_PARITY_EN
          par_d   = par_en;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt == 4'(DATA_BITS))) begin
          state_d = par_active ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_clr    = 1'b1;
          data_valid = !stp_err && !(par_active && par_err);
          if (!rx_in) begin
            // Next frame's start edge is already on the line.
            state_d = ST_START;
            ps_d    = ps_norm;
`ifdef UART_RX_PARITY_EN
            par_d   = par_en;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    // Strobes are registered, so decode one oversample early. mid+1 and
    // mid+2 never reach the bit's last oversample, so the state cannot
    // change between decode and assertion.
    samp_d    = (state_d != ST_IDLE);
    deser_d   = (state_q == ST_DATA)  && (edge_cnt == mid + PRESCALE_W'(1));
    strt_d    = (state_q == ST_START) && (edge_cnt == mid + PRESCALE_W'(1));
    stp_d     = (state_q == ST_STOP)  && (edge_cnt == mid + PRESCALE_W'(1));
`ifdef UART_RX_PARITY_EN
    par_chk_d = (state_q == ST_PARITY) &&
                ((edge_cnt == mid + PRESCALE_W'(1)) ||
                 (edge_cnt == mid + PRESCALE_W'(2)));
`else
    par_chk_d = 1'b0;
`endif
  end

  // FSM state, latched frame configuration and registered strobes.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ps_q      <= '0;
      samp_q    <= 1'b0;
      deser_q   <= 1'b0;
      strt_q    <= 1'b0;
      stp_q     <= 1'b0;
      par_chk_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      samp_q    <= samp_d;
      deser_q   <= deser_d;
      strt_q    <= strt_d;
      stp_q     <= stp_d;
      par_chk_q <= par_chk_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign dat_samp_en = samp_q;
  assign deser_en    = deser_q;
  assign strt_chk_en = strt_q;
  assign stp_chk_en  = stp_q;
  assign par_chk_en  = par_chk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fsm
// Description : Directed self-checking bench for uart_rx_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk2 = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, cyc0 = 0;
  int n_deser, n_strt, n_par, n_stp, n_samp, n_dv, n_multi;
  int dv_lat, dv_edge, dv_bit, strt_edge, stp_edge, deser_edge;

  uart_rx_fsm #(.DATA_BITS(8), .PRESCALE_W(6)) dut (
    .clk2        (clk2),
    .rst         (rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk2 = ~clk2;

  task automatic clear_counts();
    n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0; n_samp = 0; n_dv = 0; n_multi = 0;
    dv_lat = -1; dv_edge = -1; dv_bit = -1; strt_edge = -1; stp_edge = -1; deser_edge = -1;
  endtask

  // Observe one cycle on the falling edge, then move to just after the next rising edge.
  task automatic sample();
    @(negedge clk2);
    if (deser_en)    begin n_deser++; deser_edge = int'(edge_cnt); end
    if (strt_chk_en) begin n_strt++;  strt_edge  = int'(edge_cnt); end
    if (par_chk_en)  n_par++;
    if (stp_chk_en)  begin n_stp++;   stp_edge   = int'(edge_cnt); end
    if (dat_samp_en) n_samp++;
    if (int'(deser_en) + int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en) > 1) n_multi++;
    if (data_valid) begin
      n_dv++; dv_lat = cyc - cyc0; dv_edge = int'(edge_cnt); dv_bit = int'(bit_cnt);
    end
    @(posedge clk2);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  // Drive one frame. ps_in is applied at the start edge, ps_mid/pe_mid after it.
  task automatic send_frame(input int ps_in, input int ps_eff, input int ps_mid,
                            input bit pe, input bit pe_mid, input logic [7:0] data,
                            input bit b2b, input bit skip_detect);
    int nbits;
    int total;
    bit pe_eff;
    pe_eff = PAR_BUILD && pe;
    nbits  = 10 + (pe_eff ? 1 : 0);
    total  = nbits * ps_eff;
    if (!skip_detect) begin
      prescale = 6'(ps_in);
      par_en   = pe;
      rx_in    = 1'b0;
      cyc0     = cyc;
      sample();
    end else begin
      cyc0 = cyc - 1;
    end
    prescale = 6'(ps_mid);
    par_en   = pe_mid;
    for (int i = 1; i <= total; i++) begin
      int b;
      b = (i - 1) / ps_eff;
      if (b == 0)                 rx_in = 1'b0;
      else if (b <= 8)            rx_in = data[b-1];
      else if (pe_eff && b == 9)  rx_in = ^data;
      else                        rx_in = (b2b && i == total) ? 1'b0 : 1'b1;
      sample();
    end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid,
         edge_cnt, bit_cnt} !== 16'd0) $display("FAIL reset_outputs: got %h expected 0",
         {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, edge_cnt, bit_cnt});
    else n_pass++;
    rst = 1'b1;
    clear_counts();
    repeat (10) sample();
    check("reset_idle_samp", n_samp, 0);
  endtask

  task automatic test_frame_p8_parity();
    clear_counts();
    send_frame(8, 8, 8, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    check("p8_deser_cnt", n_deser, 8);
    check("p8_deser_edge", deser_edge, 6);
    check("p8_par_chk_cnt", n_par, PAR_BUILD ? 2 : 0);
    check("p8_strt_edge", strt_edge, 6);
    check("p8_stp_cnt", n_stp, 1);
    check("p8_dv_cnt", n_dv, 1);
    check("p8_dv_lat", dv_lat, PAR_BUILD ? 88 : 80);
    check("p8_dv_bit", dv_bit, PAR_BUILD ? 10 : 9);
    check("p8_samp_cycles", n_samp, PAR_BUILD ? 88 : 80);
    check("p8_onehot", n_multi, 0);
    check("p8_idle_after", int'(dat_samp_en), 0);
  endtask

  task automatic test_frame_p16();
    clear_counts();
    send_frame(16, 16, 16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
    check("p16_par_chk_cnt", n_par, 0);
    check("p16_deser_cnt", n_deser, 8);
    check("p16_strt_edge", strt_edge, 10);
    check("p16_dv_lat", dv_lat, 160);
    check("p16_dv_edge", dv_edge, 15);
    check("p16_dv_bit", dv_bit, 9);
    check("p16_idle_after", int'(dat_samp_en) + int'(bit_cnt) + int'(edge_cnt), 0);
  endtask

  task automatic test_prescale_map();
    clear_counts();
    send_frame(12, 8, 12, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    check("ps12_dv_lat", dv_lat, 80);
    check("ps12_stp_edge", stp_edge, 6);
    clear_counts();
    send_frame(32, 32, 8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);
    check("ps32_dv_lat", dv_lat, 320);
    check("ps32_strt_edge", strt_edge, 18);
    check("ps32_dv_edge", dv_edge, 31);
  endtask

  task automatic test_glitch();
    clear_counts();
    prescale = 6'd8; par_en = 1'b0; strt_glitch = 1'b1;
    cyc0 = cyc;
    rx_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) rx_in = 1'b1;
      sample();
    end
    strt_glitch = 1'b0;
    check("glitch_strt_cnt", n_strt, 1);
    check("glitch_deser_cnt", n_deser, 0);
    check("glitch_dv_cnt", n_dv, 0);
    check("glitch_samp_cycles", n_samp, 8);
    check("glitch_idle", int'(dat_samp_en) + int'(bit_cnt), 0);
  endtask

  task automatic test_errors();
    clear_counts();
    stp_err = 1'b1;
    send_frame(8, 8, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
    stp_err = 1'b0;
    check("stperr_dv_cnt", n_dv, 0);
    check("stperr_stp_cnt", n_stp, 1);
    check("stperr_idle", int'(dat_samp_en), 0);
    clear_counts();
    par_err = 1'b1;
    send_frame(8, 8, 8, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    par_err = 1'b0;
    check("parerr_dv_cnt", n_dv, PAR_BUILD ? 0 : 1);
    check("parerr_idle", int'(dat_samp_en), 0);
  endtask

  task automatic test_par_en_latch();
    clear_counts();
    send_frame(8, 8, 8, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    check("pelatch_off_par_cnt", n_par, 0);
    check("pelatch_off_dv_lat", dv_lat, 80);
    clear_counts();
    send_frame(8, 8, 8, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    check("pelatch_on_par_cnt", n_par, PAR_BUILD ? 2 : 0);
    check("pelatch_on_dv_lat", dv_lat, PAR_BUILD ? 88 : 80);
  endtask

  task automatic test_back_to_back();
    int total_dv;
    clear_counts();
    send_frame(8, 8, 16, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0);
    total_dv = n_dv;
    check("b2b_f1_dv_lat", dv_lat, 80);
    check("b2b_start_entry", {28'd0, dat_samp_en, 3'd0} + int'(edge_cnt) + int'(bit_cnt), 8);
    clear_counts();
    send_frame(16, 16, 16, 1'b0, 1'b0, 8'h69, 1'b0, 1'b1);
    total_dv += n_dv;
    check("b2b_dv_total", total_dv, 2);
    check("b2b_f2_dv_lat", dv_lat, 160);
    check("b2b_idle_after", int'(dat_samp_en), 0);
  endtask

  task automatic test_rst_mid();
    int guard;
    clear_counts();
    prescale = 6'd8; par_en = 1'b0;
    rx_in = 1'b0;
    sample();
    rx_in = 1'b1;
    guard = 0;
    while (bit_cnt != 4'd4 && guard < 200) begin
      sample();
      guard++;
    end
    check("rstmid_reach_bit4", int'(guard < 200), 1);
    check("rstmid_in_frame", int'(dat_samp_en), 1);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid,
         edge_cnt, bit_cnt} !== 16'd0) $display("FAIL rstmid_outputs: got %h expected 0",
         {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, edge_cnt, bit_cnt});
    else n_pass++;
    sample();
    rst = 1'b1;
    clear_counts();
    repeat (30) sample();
    check("rstmid_no_activity", n_samp + n_dv + n_deser, 0);
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    @(posedge clk2);
    #1;
    test_reset();
    test_frame_p8_parity();
    test_frame_p16();
    test_prescale_map();
    test_glitch();
    test_errors();
    test_par_en_latch();
    test_back_to_back();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 Parameter PRESCALE_W, default 6, width of prescale and edge_cnt.
REQ-003 clk2  input  1  oversampling clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rx_in  input  1  serial line, idle high.
REQ-006 par_en  input  1  parity bit present in frame.
REQ-007 prescale  input  PRESCALE_W  oversampling ratio (8, 16 or 32).
REQ-008 strt_glitch  input  1  start checker result, valid from edge_cnt==mid+3.
REQ-009 par_err  input  1  parity checker result, valid from edge_cnt==mid+4.
REQ-010 stp_err  input  1  stop checker result, valid from edge_cnt==mid+3.
REQ-011 dat_samp_en  output  1  sampler enable.
REQ-012 deser_en  output  1  deserializer shift strobe.
REQ-013 strt_chk_en, par_chk_en, stp_chk_en  output  1 each  checker enables.
REQ-014 data_valid  output  1  one-cycle frame-accepted strobe.
REQ-015 edge_cnt  output  PRESCALE_W  oversample index within current bit.
REQ-016 bit_cnt  output  4  bit index within frame (0 = start).

Function
REQ-017 States: IDLE, START, DATA, PARITY, STOP. Encoding: 3-bit binary.
REQ-018 Prescale is latched on IDLE->START. Values other than 16 or 32 are treated as 8. mid = latched_prescale/2.
REQ-019 IDLE->START in the cycle after rx_in==0 is sampled. edge_cnt=0 and bit_cnt=0 on START entry.
REQ-020 In non-IDLE states, edge_cnt increments each cycle. At edge_cnt==prescale-1 it wraps to 0 and bit_cnt increments.
REQ-021 dat_samp_en is high in every non-IDLE state and low in IDLE.
REQ-022 strt_chk_en, deser_en and stp_chk_en are single-cycle pulses at edge_cnt==mid+2 in START, DATA and STOP respectively.
REQ-023 par_chk_en is high for two cycles, edge_cnt==mid+2 and mid+3 in PARITY. The checker's registered data is then current when par_err is computed.
REQ-024 START at bit end: strt_glitch==1 -> IDLE (counters cleared); otherwise -> DATA.
REQ-025 DATA at end of bit DATA_BITS: par_en==1 -> PARITY; otherwise -> STOP.
REQ-026 PARITY at bit end -> STOP.
REQ-027 STOP at bit end: data_valid=1 for exactly one cycle iff stp_err==0 and (par_err==0 or parity not active).
REQ-028 STOP at bit end: next state is START if rx_in==0 in that cycle (back-to-back frame, prescale re-latched); otherwise IDLE.
REQ-029 par_en is latched at START entry. Changes mid-frame have no effect.
REQ-030 At most one of deser_en/strt_chk_en/par_chk_en/stp_chk_en is high in any cycle.

Reset
REQ-031 rst low: state=IDLE immediately, even mid-frame.
REQ-032 rst low: all outputs, edge_cnt, bit_cnt and latched prescale/par_en = 0. The first frame after release starts only on a fresh rx_in==0.

Configuration
REQ-033 With UART_RX_PARITY_EN defined, PARITY state and par_chk_en behave per REQ-023/025/026.
REQ-034 Without UART_RX_PARITY_EN: par_en and par_err are ignored, DATA always goes to STOP, par_chk_en is tied 0, and PARITY is unreachable.

Structure
REQ-035 Shared package uart_rx_pkg holds the state enum, PRESCALE_W/DATA_BITS defaults and legal-prescale constants.
REQ-036 Sub-module uart_rx_edge_bit_counter implements edge_cnt/bit_cnt (enable, wrap, clear). uart_rx_fsm instantiates it.

Verification
REQ-037 prescale=8, par_en=1, frame 0xA5 with correct even parity, stop=1: deser_en pulses 8×, par_chk_en 2 cycles, data_valid=1 at cycle 88 after start detect.
REQ-038 prescale=16, par_en=0, 0x3C: no par_chk_en, data_valid at edge_cnt=15 of bit 9; return to IDLE.
REQ-039 Start-bit low for 3 cycles, strt_glitch=1: FSM returns to IDLE at START bit end, no deser_en, data_valid stays 0.
REQ-040 par_err=1 (or stp_err=1) at STOP end: data_valid stays 0, FSM still returns to IDLE.
REQ-041 Two back-to-back frames, rx_in=0 at stop end: START entered the next cycle, two data_valid pulses.
REQ-042 rst asserted in DATA at bit 4: all outputs 0 within the same cycle; after release, idle line -> no activity.
